// File: rtl/scalar_exchange_hub_pkg.sv
// Shared types for the scalar exchange hub.
//   data_t          : scalar word exchanged between the scalar unit and the lanes
//   scalar_hub_op_t : request opcode from the scalar unit
//   hub_state_t     : hub FSM state encoding
package pkg_tpu;

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    GATHER  = 2'b00,
    BCAST   = 2'b01,
    SCATTER = 2'b10,
    GSUM    = 2'b11
  } scalar_hub_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SUM,
    ST_RESP,
    ST_DRIVE
  } hub_state_t;

endpackage

// File: rtl/scalar_exchange_hub_fresh.sv
// scalar_fresh_tracker: one bit per lane recording that the lane wrote its
// scalar-write register and that value has not yet been consumed.
//   clock, reset : system clock, synchronous active-high reset
//   set_vec      : per-lane set pulses (lane wrote its register)
//   clr_vec      : per-lane clear (value consumed by gather / gather-sum)
//   fresh        : current fresh bits
//   all_set      : every lane is fresh
module scalar_fresh_tracker #(
  parameter int NUM_LANES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] set_vec,
  input  logic [NUM_LANES-1:0] clr_vec,
  output logic [NUM_LANES-1:0] fresh,
  output logic                 all_set
);

  // A new write landing in the same cycle as a consume must not be lost,
  // so set is applied after clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fresh <= '0;
    end else begin
      fresh <= (fresh & ~clr_vec) | set_vec;
    end
  end

  assign all_set = &fresh;

endmodule

// File: rtl/scalar_exchange_hub.sv
// scalar_exchange_hub: scalar-side hub for the per-lane auxiliary scalar
// registers. Gathers a single lane's scalar, reduces all lanes by sum,
// scatters to one lane or broadcasts to all lanes.
//   clock, reset            : system clock, synchronous active-high reset
//   I_Stall                 : global stall (freezes FSM, counter, response)
//   I_Req/O_Req_Rdy         : request handshake; I_Req_Op/Lane/Data payload
//   O_Rsp_Valid/I_Rsp_Rdy   : response handshake; O_Rsp_Data payload
//   I_Lane_SWt              : per-lane scalar-write pulse
//   I_Lane_Scalar_Data      : per-lane scalar-write register contents
//   O_Lane_SWe              : per-lane scalar-read register write enable
//   O_Lane_Scalar_Data      : shared bus to the lanes' scalar-read registers
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_WAIT  | gather: wait for Fresh[lane]; gather-sum: wait for all Fresh
// ST_SUM   | accumulate one lane per cycle, Cnt = lane being added
// ST_RESP  | response valid, held until accepted
// ST_DRIVE | one-cycle write enable to the lanes (scatter/broadcast)
module scalar_exchange_hub
  import pkg_tpu::*;
#(
  parameter  int NUM_LANES = 16,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Stall,
  input  logic                 I_Req,
  output logic                 O_Req_Rdy,
  input  logic [1:0]           I_Req_Op,
  input  logic [LANE_W-1:0]    I_Req_Lane,
  input  data_t                I_Req_Data,
  output logic                 O_Rsp_Valid,
  output data_t                O_Rsp_Data,
  input  logic                 I_Rsp_Rdy,
  input  logic [NUM_LANES-1:0] I_Lane_SWt,
  input  data_t                I_Lane_Scalar_Data [NUM_LANES],
  output logic [NUM_LANES-1:0] O_Lane_SWe,
  output data_t                O_Lane_Scalar_Data
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  hub_state_t           state, state_nxt;
  scalar_hub_op_t       op_q;
  logic [LANE_W-1:0]    lane_q;
  logic [LANE_W-1:0]    cnt;
  logic [LANE_W-1:0]    sel_lane;
  data_t                acc;
  data_t                rsp_data;
  data_t                drive_data;
  data_t                lane_data;
  data_t                acc_sum;
  logic [NUM_LANES-1:0] fresh;
  logic [NUM_LANES-1:0] fresh_clr;
  logic                 all_fresh;
  logic                 accept;
  logic                 gather_hit;
  logic                 gsum_start;
  logic                 sum_last;

  scalar_fresh_tracker #(
    .NUM_LANES (NUM_LANES)
  ) u_fresh (
    .clock   (clock),
    .reset   (reset),
    .set_vec (I_Lane_SWt),
    .clr_vec (fresh_clr),
    .fresh   (fresh),
    .all_set (all_fresh)
  );

  // Single lane mux: the sum walks lanes by Cnt, everything else uses the
  // latched request lane.
  assign sel_lane  = (state == ST_SUM) ? cnt : lane_q;
  assign lane_data = I_Lane_Scalar_Data[sel_lane];
  assign acc_sum   = acc + lane_data;

  assign accept     = (state == ST_IDLE) && !I_Stall && I_Req;
  assign gather_hit = (state == ST_WAIT) && !I_Stall && (op_q == GATHER) && fresh[lane_q];
  assign gsum_start = (state == ST_WAIT) && !I_Stall && (op_q == GSUM) && all_fresh;
  assign sum_last   = (state == ST_SUM) && !I_Stall && (cnt == LAST_LANE);

  always_comb begin
    fresh_clr = '0;
    if (gather_hit) begin
      fresh_clr[lane_q] = 1'b1;
    end else if (sum_last) begin
      fresh_clr = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!I_Stall) begin
      case (state)
        ST_IDLE: begin
          if (I_Req) begin
            if ((scalar_hub_op_t'(I_Req_Op) == GATHER) || (scalar_hub_op_t'(I_Req_Op) == GSUM)) begin
              state_nxt = ST_WAIT;
            end else begin
              state_nxt = ST_DRIVE;
            end
          end
        end
        ST_WAIT: begin
          if (gather_hit) begin
            state_nxt = ST_RESP;
          end else if (gsum_start) begin
            state_nxt = ST_SUM;
          end
        end
        ST_SUM: begin
          if (cnt == LAST_LANE) begin
            state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          if (I_Rsp_Rdy) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DRIVE: state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    O_Req_Rdy   = (state == ST_IDLE) && !I_Stall;
    O_Rsp_Valid = (state == ST_RESP);
    O_Lane_SWe  = '0;
    if ((state == ST_DRIVE) && !I_Stall) begin
      if (op_q == BCAST) begin
        O_Lane_SWe = '1;
      end else begin
        O_Lane_SWe[lane_q] = 1'b1;
      end
    end
  end

  // Drive data is captured straight into the bus register so the bus
  // shows the value during DRIVE and keeps it afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= GATHER;
      lane_q     <= '0;
      cnt        <= '0;
      acc        <= '0;
      rsp_data   <= '0;
      drive_data <= '0;
    end else if (!I_Stall) begin
      if (accept) begin
        op_q   <= scalar_hub_op_t'(I_Req_Op);
        lane_q <= I_Req_Lane;
        if ((scalar_hub_op_t'(I_Req_Op) == BCAST) || (scalar_hub_op_t'(I_Req_Op) == SCATTER)) begin
          drive_data <= I_Req_Data;
        end
      end
      if (gather_hit) begin
        rsp_data <= lane_data;
      end
      if (gsum_start) begin
        acc <= '0;
        cnt <= '0;
      end
      if (state == ST_SUM) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
        if (cnt == LAST_LANE) begin
          rsp_data <= acc_sum;
        end
      end
    end
  end

  assign O_Rsp_Data         = rsp_data;
  assign O_Lane_Scalar_Data = drive_data;

endmodule

// File: doc/scalar_exchange_hub.md
# scalar_exchange_hub

Scalar-side counterpart of the per-lane auxiliary scalar registers in the TPU backend. It collects scalar values that lanes write into their scalar-write registers and returns them to the scalar unit. It also drives the per-lane scalar-read registers (write enable plus data bus), either to a single lane or broadcast to all lanes. It sits between the scalar unit and the NUM_LANES lane backends and owns a small FSM: gather, gather-sum reduction, scatter and broadcast.

## Interface
- NUM_LANES, 16, number of lanes served (power of two, at least 2)
- LANE_W, $clog2(NUM_LANES), lane index width (derived, do not override)
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- I_Stall  in  1  global stall; freezes FSM, counter and response
- I_Req  in  1  request valid from scalar unit
- O_Req_Rdy  out  1  request ready (IDLE and not stalled)
- I_Req_Op  in  2  00 gather, 01 broadcast, 10 scatter, 11 gather-sum
- I_Req_Lane  in  LANE_W  target lane for gather/scatter
- I_Req_Data  in  data_t  data for broadcast/scatter
- O_Rsp_Valid  out  1  response valid (gather, gather-sum)
- O_Rsp_Data  out  data_t  response data
- I_Rsp_Rdy  in  1  response accepted
- I_Lane_SWt  in  NUM_LANES  per-lane pulse: the lane wrote its scalar-write register this cycle
- I_Lane_Scalar_Data  in  NUM_LANES x data_t  per-lane scalar-write register contents
- O_Lane_SWe  out  NUM_LANES  per-lane scalar-read register write enable
- O_Lane_Scalar_Data  out  data_t  shared data bus to all lanes' scalar-read registers

## Operation
- Fresh[NUM_LANES]: a bit is set by I_Lane_SWt[i], cleared when lane i is consumed by gather or gather-sum. Set and clear in the same cycle: set wins. Fresh updates ignore I_Stall.
- FSM states: IDLE, WAIT, SUM, RESP, DRIVE.
- IDLE: O_Req_Rdy=1 when ~I_Stall. On accept, latch Op, Lane and Data, then:
  - gather and gather-sum go to WAIT;
  - broadcast and scatter go to DRIVE.
- WAIT:
  - gather: when Fresh[Lane], latch I_Lane_Scalar_Data[Lane] into the response, clear Fresh[Lane], go to RESP.
  - gather-sum: when all Fresh bits are set, clear Acc and Cnt, go to SUM.
- SUM: each cycle Acc += I_Lane_Scalar_Data[Cnt] and Cnt++. The add is modulo 2^width(data_t), carry discarded. After Cnt=NUM_LANES-1, clear all Fresh bits and go to RESP with the response equal to the final Acc.
- RESP: O_Rsp_Valid=1 and O_Rsp_Data held stable until I_Rsp_Rdy, then go to IDLE.
- DRIVE: O_Lane_Scalar_Data = latched data for one cycle, then IDLE.
  - Broadcast: O_Lane_SWe all ones.
  - Scatter: O_Lane_SWe one-hot at Lane.
- O_Lane_SWe is 0 in every state other than DRIVE.
- O_Lane_Scalar_Data holds its last driven value outside DRIVE.

## Timing
- Reset: state IDLE; Fresh, Acc, Cnt and the response register are 0. All outputs are 0 except O_Req_Rdy, which is 1 on the first cycle after reset when I_Stall=0.
- Reset mid-operation aborts the operation; no partial SWe or response is issued afterwards.
- Broadcast/scatter accepted at cycle t: O_Lane_SWe is high in t+1, and the lane register updates at the t+2 edge.
- Gather with Fresh already set at acceptance (cycle t): O_Rsp_Valid rises in t+2. If I_Lane_SWt arrives at cycle u, Fresh is seen in u+1 and the response is valid in u+2.
- Gather-sum: O_Rsp_Valid rises NUM_LANES+1 cycles after the cycle in which all Fresh bits are seen set.
- I_Stall high: state, Cnt and Acc hold, and O_Req_Rdy=0. In DRIVE, O_Lane_SWe is forced to 0 and the state is held, so the drive issues once after the stall releases. In RESP, O_Rsp_Valid stays asserted but a handshake does not complete.
- Back-to-back requests: at most one request outstanding; the next request is accepted no earlier than the cycle after the FSM returns to IDLE.

## Structure
- pkg_tpu: data_t (existing); add the scalar_hub_op_t enum (GATHER, BCAST, SCATTER, GSUM) and the FSM state enum.
- One sub-module is natural: scalar_fresh_tracker, containing the Fresh bit vector with its set/clear-priority logic and an all-set flag.
- The lane mux and accumulator stay in the top module.

## Test plan
- Lane 3 pulses I_Lane_SWt with data 0x0000_00A5; gather lane 3 -> O_Rsp_Data=0x0000_00A5, Fresh[3] cleared afterwards.
- Gather lane 5 issued with Fresh[5]=0, then I_Lane_SWt[5] 10 cycles later -> response exactly 2 cycles after the pulse.
- Broadcast 0xDEAD_BEEF -> O_Lane_SWe=all ones for exactly one cycle, bus=0xDEAD_BEEF; scatter lane 7 -> O_Lane_SWe=0x0080.
- Gather-sum with all 16 lanes holding 0x1000_0000 -> O_Rsp_Data=0x0000_0000 (wrap-around); with lane i holding i -> 120.
- I_Stall held 3 cycles during DRIVE and during SUM -> a single SWe pulse after release; the sum is unchanged; I_Rsp_Rdy=0 for 5 cycles keeps the response stable.
- Reset asserted in SUM -> state IDLE, Fresh=0, no O_Rsp_Valid; I_Lane_SWt[2] and a gather-clear of lane 2 in the same cycle -> Fresh[2]=1.
